// File: rtl/mul_arbiter_if.sv
// Requester/multiplier/response bundle for mul_arbiter.
// The slave modport is the arbiter side; master is the environment side.
interface mul_arbiter_if #(
   parameter int WIDTH = 6,
   parameter int NREQ  = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]             req_valid;
   logic [NREQ-1:0]             req_ready;
   logic [NREQ-1:0][WIDTH-1:0]  req_a;
   logic [NREQ-1:0][WIDTH-1:0]  req_b;
   logic [WIDTH-1:0]            mul_in1;
   logic [WIDTH-1:0]            mul_in2;
   logic [2*WIDTH-1:0]          mul_out;
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [IDW-1:0]              rsp_id;
   logic [2*WIDTH-1:0]          rsp_data;

   modport slave (
      input  req_valid, req_a, req_b, mul_out, rsp_ready,
      output req_ready, mul_in1, mul_in2, rsp_valid, rsp_id, rsp_data
   );

   modport master (
      output req_valid, req_a, req_b, mul_out, rsp_ready,
      input  req_ready, mul_in1, mul_in2, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one external combinational multiplier (IDLE/MUL/RESP).
// Define MUL_ARBITER_STATS_EN to add a saturating 16-bit handshake counter (op_count).
module mul_arbiter #(
   parameter int WIDTH = 6,
   parameter int NREQ  = 4
) (
   input  logic               clk,
   input  logic               rst,
`ifdef MUL_ARBITER_STATS_EN
   output logic [15:0]        op_count,
`endif
   mul_arbiter_if.slave       bus
);
   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

   state_t              r_state;
   logic [IDW-1:0]      r_ptr;
   logic [IDW-1:0]      r_id;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [2*WIDTH-1:0]  r_data;
   logic                r_rsp_valid;

   logic                w_gnt_vld;
   logic [IDW-1:0]      w_gnt_idx;
   logic [IDW-1:0]      w_scan;
   logic [NREQ-1:0]     w_ready;

   // Scan from the highest offset down so the requester closest to r_ptr wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_scan    = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         w_scan = IDW'((int'(r_ptr) + i) % NREQ);
         if (bus.req_valid[w_scan]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_scan;
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if (!rst && r_state == IDLE && w_gnt_vld)
         w_ready[w_gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_id        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_data      <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_gnt_vld) begin
               r_a     <= bus.req_a[w_gnt_idx];
               r_b     <= bus.req_b[w_gnt_idx];
               r_id    <= w_gnt_idx;
               r_ptr   <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
               r_state <= MUL;
            end
            MUL: begin
               r_data      <= bus.mul_out;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: if (bus.rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef MUL_ARBITER_STATS_EN
   logic [15:0] r_op_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_op_count <= '0;
      else if (r_state == RESP && bus.rsp_ready && r_op_count != 16'hFFFF)
         r_op_count <= r_op_count + 16'd1;
   end

   assign op_count = r_op_count;
`endif

   assign bus.req_ready = w_ready;
   assign bus.mul_in1   = r_a;
   assign bus.mul_in2   = r_b;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_id    = r_id;
   assign bus.rsp_data  = r_data;
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: vector table for single grants plus reset,
// continuous round-robin and backpressure sequences.
module tb_mul_arbiter;
   localparam int WIDTH = 6;
   localparam int NREQ  = 4;

   logic clk;
   logic rst;
`ifdef MUL_ARBITER_STATS_EN
   logic [15:0] op_count;
`endif

   mul_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef MUL_ARBITER_STATS_EN
      .op_count (op_count),
`endif
      .bus      (bus)
   );

   // Shared multiplier lives outside the arbiter.
   assign bus.mul_out = bus.mul_in1 * bus.mul_in2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [5:0]  a;
      logic [5:0]  b;
      logic [1:0]  id;
      logic [11:0] data;
   } vec_t;

   vec_t vecs [7];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Granted lane carries the operands; every other lane carries 1*1.
   task automatic set_ops(input int lane, input logic [5:0] a, input logic [5:0] b);
      for (int k = 0; k < NREQ; k++) begin
         bus.req_a[k] = (k == lane) ? a : 6'd1;
         bus.req_b[k] = (k == lane) ? b : 6'd1;
      end
   endtask

   // One full transaction from IDLE with rsp_ready held high.
   task automatic do_op(input logic [3:0] valid, input logic [5:0] a, input logic [5:0] b,
                        input logic [1:0] id, input logic [11:0] data);
      logic [3:0] exp_rdy;
      exp_rdy = 4'b0001 << id;
      set_ops(int'(id), a, b);
      bus.req_valid = valid;
      bus.rsp_ready = 1'b1;
      #1;
      chk("grant_ready", bus.req_ready, exp_rdy);
      tick();
      bus.req_valid = '0;
      #1;
      chk("mul_ready_zero", bus.req_ready, 0);
      chk("mul_rsp_valid_low", bus.rsp_valid, 0);
      tick();
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_id", bus.rsp_id, id);
      chk("rsp_data", bus.rsp_data, data);
      tick();
      chk("rsp_dropped", bus.rsp_valid, 0);
   endtask

   initial begin
      int order [5];
      int nrsp;
      int last_n;

      vecs[0] = '{4'b0100, 6'd63, 6'd63, 2'd2, 12'd3969};
      vecs[1] = '{4'b1111, 6'd5,  6'd7,  2'd3, 12'd35};
      vecs[2] = '{4'b0110, 6'd0,  6'd45, 2'd1, 12'd0};
      vecs[3] = '{4'b0110, 6'd10, 6'd20, 2'd2, 12'd200};
      vecs[4] = '{4'b0011, 6'd63, 6'd1,  2'd0, 12'd63};
      vecs[5] = '{4'b1001, 6'd2,  6'd33, 2'd3, 12'd66};
      vecs[6] = '{4'b0001, 6'd12, 6'd12, 2'd0, 12'd144};
      order   = '{0, 1, 2, 3, 0};

      rst = 1'b1;
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      set_ops(0, 6'd9, 6'd9);
      tick();
      tick();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_mul_in1", bus.mul_in1, 0);
      chk("rst_mul_in2", bus.mul_in2, 0);

      bus.req_valid = '0;
      rst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         #1;
         chk("idle_ready_zero", bus.req_ready, 0);
         chk("idle_no_rsp", bus.rsp_valid, 0);
         tick();
      end

      for (int i = 0; i < 7; i++)
         do_op(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].id, vecs[i].data);

      // Reset while in MUL: pointer is 1 after the table.
      set_ops(1, 6'd7, 6'd7);
      bus.req_valid = 4'b1111;
      #1;
      chk("pre_rst_grant", bus.req_ready, 4'b0010);
      tick();
      bus.req_valid = '0;
      rst = 1'b1;
      #1;
      chk("midrst_rsp_valid", bus.rsp_valid, 0);
      chk("midrst_ready", bus.req_ready, 0);
      chk("midrst_mul_in1", bus.mul_in1, 0);
      chk("midrst_mul_in2", bus.mul_in2, 0);
      chk("midrst_rsp_data", bus.rsp_data, 0);
      tick();
      tick();
      chk("midrst_no_rsp", bus.rsp_valid, 0);
      rst = 1'b0;

      // Continuous requests from all lanes: lane k computes (k+1)*3.
      for (int k = 0; k < NREQ; k++) begin
         bus.req_a[k] = 6'(k + 1);
         bus.req_b[k] = 6'd3;
      end
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      #1;
      chk("rr_first_grant_lane0", bus.req_ready, 4'b0001);
      nrsp   = 0;
      last_n = 0;
      for (int n = 0; n < 16; n++) begin
         if (bus.rsp_valid) begin
            if (nrsp < 5) begin
               chk("rr_id", bus.rsp_id, order[nrsp]);
               chk("rr_data", bus.rsp_data, (order[nrsp] + 1) * 3);
            end
            if (nrsp > 0)
               chk("rr_spacing", n - last_n, 3);
            last_n = n;
            nrsp++;
         end
         tick();
      end
      chk("rr_count", nrsp, 5);

      bus.req_valid = '0;
      for (int n = 0; n < 4; n++) tick();

      // Backpressure on lane 1 while it keeps requesting.
      set_ops(1, 6'd5, 6'd7);
      bus.req_valid = 4'b0010;
      bus.rsp_ready = 1'b0;
      #1;
      chk("bp_grant", bus.req_ready, 4'b0010);
      tick();
      tick();
      for (int n = 0; n < 5; n++) begin
         chk("bp_valid_held", bus.rsp_valid, 1);
         chk("bp_data_held", bus.rsp_data, 35);
         chk("bp_id_held", bus.rsp_id, 1);
         chk("bp_no_grant", bus.req_ready, 0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      tick();
      chk("bp_released", bus.rsp_valid, 0);
      chk("bp_regrant", bus.req_ready, 4'b0010);
      bus.req_valid = '0;
      for (int n = 0; n < 4; n++) tick();

`ifdef MUL_ARBITER_STATS_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("stats_reset", op_count, 0);
      do_op(4'b0001, 6'd2, 6'd3, 2'd0, 12'd6);
      do_op(4'b0010, 6'd2, 6'd4, 2'd1, 12'd8);
      do_op(4'b0100, 6'd2, 6'd5, 2'd2, 12'd10);
      chk("stats_three", op_count, 3);
      force dut.r_op_count = 16'hFFFF;
      tick();
      release dut.r_op_count;
      do_op(4'b1000, 6'd3, 6'd3, 2'd3, 12'd9);
      chk("stats_saturate", op_count, 16'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the operand width of the shared multiplier.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, NREQ bits, with one request-valid bit per requester.
REQ-006 The block SHALL have port req_ready, output, NREQ bits, with one accept strobe per requester.
REQ-007 The block SHALL have port req_a, input, NREQ x WIDTH bits, carrying the per-requester multiplicand.
REQ-008 The block SHALL have port req_b, input, NREQ x WIDTH bits, carrying the per-requester multiplier.
REQ-009 The block SHALL have port mul_in1, output, WIDTH bits, the operand to the shared combinational multiplier.
REQ-010 The block SHALL have port mul_in2, output, WIDTH bits, the second operand to the shared combinational multiplier.
REQ-011 The block SHALL have port mul_out, input, 2*WIDTH bits, the product returned by the shared multiplier.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit, indicating that the response is valid.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit, the consumer backpressure.
REQ-014 The block SHALL have port rsp_id, output, clog2(NREQ) bits, the index of the requester that owns the response.
REQ-015 The block SHALL have port rsp_data, output, 2*WIDTH bits, the registered product.

Function
REQ-016 The block SHALL implement the FSM states IDLE, MUL and RESP, one operation in flight at a time.
REQ-017 In IDLE with any req_valid set, the block SHALL select one requester round-robin, assert only that requester's req_ready for one cycle, register its operands and id, and go to MUL.
REQ-018 Round-robin priority SHALL start after the last granted index (pointer = last+1 mod NREQ); after reset the pointer SHALL be 0.
REQ-019 req_ready SHALL be zero in MUL and RESP, and zero in IDLE when no req_valid is set.
REQ-020 mul_in1 and mul_in2 SHALL be driven only from the operand registers, never combinationally from req_a or req_b.
REQ-021 In MUL the block SHALL capture mul_out into rsp_data, assert rsp_valid on the next cycle and go to RESP; mul_out SHALL be assumed settled within one cycle.
REQ-022 In RESP, rsp_valid, rsp_id and rsp_data SHALL stay stable until rsp_ready is sampled high.
REQ-023 On that edge, the block SHALL drop rsp_valid and return to IDLE.
REQ-024 The minimum request-to-response latency SHALL be 2 cycles from the accept edge to rsp_valid high, and the minimum throughput SHALL be one operation per 3 cycles.
REQ-025 A requester that drops req_valid before it is granted SHALL NOT be served, and no request SHALL be queued.
REQ-026 The product SHALL be unsigned, full 2*WIDTH bits, with no overflow indication.
REQ-027 If rsp_ready is held high continuously, the block SHALL still pass through RESP for one cycle.

Reset
REQ-028 While rst is high, the block SHALL set the state to IDLE and drive req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, mul_in1=0, mul_in2=0, and the RR pointer to 0.
REQ-029 If rst is asserted mid-operation, the in-flight operation SHALL be discarded with no response emitted.
REQ-030 The first grant after rst deasserts SHALL occur no earlier than the first rising clk edge.

Configuration
REQ-031 When the macro MUL_ARBITER_STATS_EN is defined, the block SHALL add output op_count, 16 bits, which increments on each rsp_valid && rsp_ready handshake, saturates at 0xFFFF, and is reset to 0 by rst.
REQ-032 When MUL_ARBITER_STATS_EN is undefined, op_count SHALL be absent and there SHALL be no counter logic.

Verification
REQ-033 Single request: NREQ=4, req 2 valid with a=6'd63, b=6'd63 and rsp_ready=1 -> req_ready[2] for 1 cycle, then rsp_valid 2 cycles later with rsp_id=2 and rsp_data=12'd3969.
REQ-034 All 4 requesters held valid continuously -> grant order 0,1,2,3,0, with responses 3 cycles apart.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles with a=5, b=7 -> rsp_data=35 held stable for all 5 cycles; a new grant occurs only after the handshake.
REQ-036 Asserting rst during MUL -> no rsp_valid, all outputs 0, and the next grant goes to requester 0.
REQ-037 Zero operand a=0, b=45 -> rsp_data=0, and the RR pointer still advances.
REQ-038 With MUL_ARBITER_STATS_EN defined, 3 handshakes -> op_count=3; a forced count of 0xFFFF stays at 0xFFFF after another handshake.
